// File: rtl/pulse_sched_if.sv
// Request/grant/pulse bundle shared by the pulse scheduler and its requesters.
interface pulse_sched_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]         req;
  logic [N*W-1:0]       dly;
  logic [N*W-1:0]       len;
  logic                 abort;
  logic [N-1:0]         gnt;
  logic [N-1:0]         done;
  logic                 pulse;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;

  modport master (output req, dly, len, abort, input gnt, done, pulse, owner, busy);
  modport slave  (input req, dly, len, abort, output gnt, done, pulse, owner, busy);
endinterface

// File: rtl/pulse_sched.sv
// Round-robin arbiter driving one shared pulse generator: after a grant, waits
// dly cycles, emits a len-cycle registered pulse, then strobes done to the owner.
module pulse_sched #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  pulse_sched_if.slave bus
);
  localparam int OW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DLY, PULSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    len_q, len_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic            pulse_q, pulse_d;
  logic [OW-1:0]   win;
  logic            found;

  // Search starts one past the last winner so a held request cannot starve others.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = int'(last_q) + k;
      if (j >= N) j = j - N;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win   = OW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    pulse_d = pulse_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          last_d       = win;
          cnt_d        = bus.dly[int'(win)*W +: W];
          len_d        = bus.len[int'(win)*W +: W];
          state_d      = DLY;
        end
      end
      DLY: begin
        if (bus.abort || (cnt_q == '0 && len_q == '0)) begin
          gnt_d           = '0;
          done_d[owner_q] = 1'b1;
          pulse_d         = 1'b0;
          state_d         = DONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          pulse_d = 1'b1;
          cnt_d   = len_q - 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (bus.abort || cnt_q == '0) begin
          gnt_d           = '0;
          done_d[owner_q] = 1'b1;
          pulse_d         = 1'b0;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N-1);
      gnt_q   <= '0;
      done_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.pulse = pulse_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_pulse_sched.sv
// Directed checks of pulse_sched (N=4, W=8) with hand-computed expectations.
module tb_pulse_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pulse_sched_if #(.N(4), .W(8)) bus ();
  pulse_sched #(.N(4), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int npulse;
    int ndone;
    rst       = 1'b1;
    bus.req   = '0;
    bus.dly   = '0;
    bus.len   = '0;
    bus.abort = 1'b0;
    #12;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pulse", 32'(bus.pulse), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    rst = 1'b0;

    // basic: dly=3 len=2; dly/len changed after grant must be ignored
    bus.req = 4'b0001;
    bus.dly[0 +: 8] = 8'd3;
    bus.len[0 +: 8] = 8'd2;
    tick(); // E0
    chk("b_gnt", 32'(bus.gnt), 32'b0001);
    chk("b_busy", 32'(bus.busy), 1);
    chk("b_owner", 32'(bus.owner), 0);
    bus.dly[0 +: 8] = 8'd0;
    bus.len[0 +: 8] = 8'd7;
    tick(); tick(); tick(); // E3
    chk("b_pulse_e3", 32'(bus.pulse), 0);
    tick(); // E4
    chk("b_pulse_e4", 32'(bus.pulse), 1);
    tick(); // E5
    chk("b_pulse_e5", 32'(bus.pulse), 1);
    tick(); // E6
    chk("b_pulse_e6", 32'(bus.pulse), 0);
    chk("b_done_e6", 32'(bus.done), 32'b0001);
    chk("b_gnt_e6", 32'(bus.gnt), 0);
    bus.req = '0;
    tick(); // E7
    chk("b_done_e7", 32'(bus.done), 0);
    chk("b_busy_e7", 32'(bus.busy), 0);

    // zero delay and zero length
    bus.req = 4'b0100;
    bus.dly[16 +: 8] = 8'd0;
    bus.len[16 +: 8] = 8'd0;
    tick();
    chk("z_gnt", 32'(bus.gnt), 32'b0100);
    chk("z_owner", 32'(bus.owner), 2);
    bus.req = '0;
    tick();
    chk("z_done", 32'(bus.done), 32'b0100);
    chk("z_pulse", 32'(bus.pulse), 0);
    tick();
    chk("z_done_clr", 32'(bus.done), 0);

    // round robin from reset, all requesting, dly=0 len=1 -> 4-cycle period
    rst = 1'b1; #2; rst = 1'b0;
    bus.req = 4'b1111;
    bus.dly = 32'h0000_0000;
    bus.len = 32'h0101_0101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      chk("rr_owner", 32'(bus.owner), 32'(k % 4));
      if (k == 4) bus.req = '0;
      tick();
      chk("rr_pulse", 32'(bus.pulse), 1);
      chk("rr_onehot", 32'($onehot0(bus.gnt)), 1);
      tick();
      chk("rr_done", 32'(bus.done), 32'(1 << (k % 4)));
      chk("rr_gnt_clr", 32'(bus.gnt), 0);
      tick();
      chk("rr_idle", 32'(bus.busy), 0);
    end

    // abort on the 3rd pulse-high cycle; last owner is 0 so requester 1 wins
    bus.req = 4'b0010;
    bus.dly[8 +: 8] = 8'd2;
    bus.len[8 +: 8] = 8'd10;
    tick(); // E0
    chk("a_gnt", 32'(bus.gnt), 32'b0010);
    tick(); tick(); tick(); // E3
    chk("a_pulse_e3", 32'(bus.pulse), 1);
    tick(); tick(); // E5
    chk("a_pulse_e5", 32'(bus.pulse), 1);
    bus.abort = 1'b1;
    tick(); // E6
    chk("a_pulse_e6", 32'(bus.pulse), 0);
    chk("a_done", 32'(bus.done), 32'b0010);
    // abort held through DONE and IDLE must not block the next grant
    bus.req = 4'b0001;
    bus.dly[0 +: 8] = 8'd1;
    bus.len[0 +: 8] = 8'd1;
    tick(); // E7 DONE->IDLE
    chk("a_done_clr", 32'(bus.done), 0);
    chk("a_idle", 32'(bus.busy), 0);
    tick(); // E8 grant despite abort
    chk("a_next_gnt", 32'(bus.gnt), 32'b0001);
    bus.abort = 1'b0;
    bus.req   = '0;
    tick(); tick(); // E10
    chk("a_next_pulse", 32'(bus.pulse), 1);
    tick(); // E11
    chk("a_next_done", 32'(bus.done), 32'b0001);
    tick();

    // async reset mid-PULSE
    bus.req = 4'b0100;
    bus.dly[16 +: 8] = 8'd0;
    bus.len[16 +: 8] = 8'd5;
    tick(); tick(); tick();
    chk("r_pulse_pre", 32'(bus.pulse), 1);
    bus.req = '0;
    #2 rst = 1'b1;
    #1;
    chk("r_pulse", 32'(bus.pulse), 0);
    chk("r_gnt", 32'(bus.gnt), 0);
    chk("r_busy", 32'(bus.busy), 0);
    tick();
    chk("r_done_held", 32'(bus.done), 0);
    rst = 1'b0;
    tick();
    chk("r_done_after", 32'(bus.done), 0);
    chk("r_busy_after", 32'(bus.busy), 0);

    // req dropped during DLY: full pulse and done still happen
    bus.req = 4'b1000;
    bus.dly[24 +: 8] = 8'd2;
    bus.len[24 +: 8] = 8'd3;
    tick();
    chk("d_gnt", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    npulse = 0;
    ndone  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.pulse) npulse++;
      if (bus.done == 4'b1000) ndone++;
    end
    chk("d_pulse_len", 32'(npulse), 3);
    chk("d_done_cnt", 32'(ndone), 1);
    chk("d_idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_sched.md
PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8: width of the delay, length and counter fields.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, N: per-requester level request, held until its done.
REQ-006 SHALL have port dly, input, N*W: packed per-requester delay; slice i = dly[i*W +: W].
REQ-007 SHALL have port len, input, N*W: packed per-requester pulse length, same packing as dly.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of the current operation.
REQ-009 SHALL have port gnt, output, N: one-hot grant, at most one bit set.
REQ-010 SHALL have port done, output, N: one-cycle completion strobe to the owner.
REQ-011 SHALL have port pulse, output, 1: the shared generated pulse, registered.
REQ-012 SHALL have port owner, output, $clog2(N): index of the current or last grantee.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL use FSM states IDLE, DLY, PULSE, DONE.
REQ-015 IDLE with any req bit set at edge E0 SHALL produce the following updates at E0:
- winner selected round-robin, priority order starting at last_owner+1 and wrapping modulo N;
- gnt[winner] set, owner <= winner, last_owner <= winner;
- cnt <= dly slice of winner, len_r <= len slice of winner;
- state <= DLY.
REQ-016 dly and len SHALL be sampled only at the grant edge; later changes to them SHALL be ignored.
REQ-017 DLY with cnt != 0 SHALL decrement cnt.
REQ-018 DLY with cnt == 0 and len_r == 0 SHALL go to DONE with no pulse.
REQ-019 DLY with cnt == 0 and len_r != 0 SHALL set pulse <= 1, cnt <= len_r-1, state <= PULSE.
REQ-020 PULSE with cnt != 0 SHALL decrement cnt.
REQ-021 PULSE with cnt == 0 SHALL set pulse <= 0 and state <= DONE.
REQ-022 Cycle timing SHALL be as follows:
- pulse rises at edge E(dly+1);
- pulse is high for exactly len cycles;
- pulse falls at edge E(dly+len+1).
REQ-023 Each transition into DONE SHALL, at the same edge:
- clear gnt;
- set done[owner] for exactly one cycle;
- force pulse to 0.
REQ-024 DONE SHALL return to IDLE on the next edge and clear done; no arbitration SHALL occur in DONE.
REQ-025 The minimum spacing SHALL be one IDLE cycle between done and the next grant.
REQ-026 A req that is still high at the first IDLE edge SHALL count as a new request.
REQ-027 Dropping req while granted SHALL be ignored; the operation SHALL run to completion.
REQ-028 abort high in DLY or PULSE SHALL go to DONE at that edge (pulse <= 0, done[owner] <= 1); abort SHALL have priority over the counter transitions.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 Counters SHALL be W bits with no wrap-around; the maximum values are dly = len = 2^W-1.
REQ-031 A requester winning arbitration SHALL not be granted again while any other req is pending.

Reset
REQ-032 rst high SHALL immediately (asynchronously) set the following:
- state IDLE, gnt = 0, done = 0, pulse = 0, busy = 0;
- owner = 0, cnt = 0, len_r = 0;
- last_owner = N-1, so that requester 0 has first priority.
REQ-033 rst asserted mid-operation SHALL drop pulse with no done strobe; outputs SHALL hold reset values until the first edge after rst is released.

Verification (N=4, W=8)
REQ-034 Basic request: req[0]=1, dly0=3, len0=2.
- gnt=0001 after E0;
- pulse high from E4 to E6 (exactly 2 cycles);
- done=0001 for one cycle after E6, then idle.
REQ-035 Zero delay and length: dly2=0, len2=0, req[2] only.
- gnt=0100 after E0;
- pulse never rises;
- done=0100 for one cycle after E1.
REQ-036 Round-robin: req=1111 held continuously from reset.
- grant order 0, 1, 2, 3, 0;
- gnt always one-hot;
- one IDLE cycle between each done and the next gnt.
REQ-037 Abort: req[1], dly1=2, len1=10, abort pulsed for one cycle on the 3rd pulse-high cycle.
- pulse low at that edge;
- done=0010 for one cycle;
- next grant proceeds normally.
REQ-038 Reset and request drop:
- rst asserted mid-PULSE: pulse/gnt/busy go to 0 without a clock edge, and done never fires.
- req dropped during DLY: the pulse still completes with full len, and done still fires.
